// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C-style register target. It decodes ID/sub-address/data
// writes and ID/data reads, and keeps the results in a 256x8 register file.
// SDA is open drain: this block only ever pulls it low or releases it.
module sccb_target #(
    parameter logic [7:0]  DEVICE_ID   = 8'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       busy,
    output logic [7:0] nack_count
);

    localparam int unsigned SYNC_DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned REG_DEPTH  = 256;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_ID_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

    state_t state, state_next;

    logic [SYNC_DEPTH-1:0] scl_sync, sda_sync;
    logic       scl_q, sda_q;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;

    logic [2:0] bit_cnt, bit_cnt_next;
    logic [6:0] shift, shift_next;
    logic [7:0] byte_in;
    logic [7:0] sub_addr, sub_addr_next;
    logic [7:0] rd_byte, rd_byte_next;
    logic [7:0] rd_word;
    logic       rw, rw_next;
    logic       ack_phase, ack_phase_next;
    logic       sda_oe, sda_oe_next;
    logic       busy_next;
    logic       wr_req;
    logic       nack_inc;

    logic [7:0] regfile [REG_DEPTH];

    assign sda = sda_oe ? 1'b0 : 1'bz;

    assign scl_s     = scl_sync[SYNC_DEPTH-1];
    assign sda_s     = sda_sync[SYNC_DEPTH-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
    assign byte_in   = {shift, sda_s};
    assign rd_word   = regfile[sub_addr];
    assign dbg_data  = regfile[dbg_addr];

    // Bring SCL/SDA into the clk domain and keep one-cycle-old copies for edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_DEPTH-2:0], scl};
            sda_sync <= {sda_sync[SYNC_DEPTH-2:0], sda};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    // State and protocol datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd7;
            shift      <= 7'd0;
            sub_addr   <= 8'd0;
            rd_byte    <= 8'd0;
            rw         <= 1'b0;
            ack_phase  <= 1'b0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            nack_count <= 8'd0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            shift     <= shift_next;
            sub_addr  <= sub_addr_next;
            rd_byte   <= rd_byte_next;
            rw        <= rw_next;
            ack_phase <= ack_phase_next;
            sda_oe    <= sda_oe_next;
            busy      <= busy_next;
            if (nack_inc && nack_count != 8'hFF) begin
                nack_count <= nack_count + 8'd1;
            end
        end
    end

    // Write strobe: one-cycle pulse carrying the address/data just received.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= 8'd0;
            reg_wr_data <= 8'd0;
        end else begin
            reg_wr_en <= wr_req;
            if (wr_req) begin
                reg_wr_addr <= sub_addr;
                reg_wr_data <= byte_in;
            end
        end
    end

    // Register file, updated from the registered strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regfile[i] <= 8'h00;
            end
        end else if (reg_wr_en) begin
            regfile[reg_wr_addr] <= reg_wr_data;
        end
    end

    // Next-state and datapath decode; START/STOP override bit handling.
    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        shift_next     = shift;
        sub_addr_next  = sub_addr;
        rd_byte_next   = rd_byte;
        rw_next        = rw;
        ack_phase_next = ack_phase;
        sda_oe_next    = sda_oe;
        busy_next      = busy;
        wr_req         = 1'b0;
        nack_inc       = 1'b0;

        if (start_det) begin
            state_next     = ST_ID;
            bit_cnt_next   = 3'd7;
            ack_phase_next = 1'b0;
            sda_oe_next    = 1'b0;
            busy_next      = 1'b1;
        end else if (stop_det) begin
            state_next     = ST_IDLE;
            ack_phase_next = 1'b0;
            sda_oe_next    = 1'b0;
            busy_next      = 1'b0;
        end else begin
            case (state)
                ST_ID, ST_SUB, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_next   = byte_in[6:0];
                        bit_cnt_next = bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
                            ack_phase_next = 1'b0;
                            if (state == ST_ID) begin
                                if (byte_in[7:1] == DEVICE_ID[7:1]) begin
                                    rw_next    = byte_in[0];
                                    state_next = ST_ID_ACK;
                                end else begin
                                    nack_inc   = 1'b1;
                                    state_next = ST_IGNORE;
                                end
                            end else if (state == ST_SUB) begin
                                sub_addr_next = byte_in;
                                state_next    = ST_SUB_ACK;
                            end else begin
                                wr_req        = 1'b1;
                                sub_addr_next = sub_addr + 8'd1;
                                state_next    = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                    // First falling edge asserts ACK, second ends the slot.
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe_next    = 1'b1;
                            ack_phase_next = 1'b1;
                        end else begin
                            ack_phase_next = 1'b0;
                            bit_cnt_next   = 3'd7;
                            if (state == ST_ID_ACK && rw) begin
                                rd_byte_next = rd_word;
                                sda_oe_next  = ~rd_word[7];
                                state_next   = ST_RDATA;
                            end else begin
                                sda_oe_next = 1'b0;
                                state_next  = (state == ST_ID_ACK) ? ST_SUB : ST_WDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    // Bit already on the bus is consumed on the rise; next one set up on the fall.
                    if (scl_rise) begin
                        if (bit_cnt == 3'd0) begin
                            ack_phase_next = 1'b0;
                            state_next     = ST_RDATA_ACK;
                        end else begin
                            bit_cnt_next = bit_cnt - 3'd1;
                        end
                    end else if (scl_fall) begin
                        sda_oe_next = ~rd_byte[bit_cnt];
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_fall && !ack_phase) begin
                        sda_oe_next    = 1'b0;
                        ack_phase_next = 1'b1;
                        sub_addr_next  = sub_addr + 8'd1;
                    end else if (scl_rise && ack_phase) begin
                        ack_phase_next = 1'b0;
                        if (!sda_s) begin
                            bit_cnt_next = 3'd7;
                            rd_byte_next = rd_word;
                            state_next   = ST_RDATA;
                        end else begin
                            state_next = ST_IGNORE;
                        end
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    state_next = state;
                end
                default: begin
                    state_next  = ST_IDLE;
                    sda_oe_next = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
SCCB/I2C-style target (responder) modelling the camera's register interface. It decodes 3-phase writes and 2-phase reads from the camera-config initiator and stores the results in an internal 256x8 register file. It is used for loopback and bench checking of the camera configuration sequence, and as a stand-in camera register block on the FPGA. It receives SCL and open-drain SDA and drives SDA only low (ACK and read data).

Parameters:
- DEVICE_ID, 8'h42, write address; bits [7:1] are matched, bit 0 is R/W.
- SYNC_STAGES, 2, synchronizer depth on SCL and SDA (minimum 2).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- scl  input  1  SCCB clock from initiator; released level reads as 1 (external/bench pull-up)
- sda  inout  1  open drain; driven 0 or high-Z only
- reg_wr_en  output  1  one-clk pulse per completed data byte written
- reg_wr_addr  output  8  address of the write being strobed
- reg_wr_data  output  8  data of the write being strobed
- dbg_addr  input  8  debug read address
- dbg_data  output  8  register file [dbg_addr], combinational
- busy  output  1  high from START detect to STOP detect
- nack_count  output  8  count of ignored (non-matching ID) transactions; saturates at 8'hFF

Behaviour:
- Input conditioning: scl and sda each pass through SYNC_STAGES flops, giving scl_s and sda_s. Previous-cycle copies provide edge detection.
- Timing constraint: SCL high and low times must each be at least SYNC_STAGES+3 clk periods. Faster SCL is unsupported.
- START: scl_s high on both samples and sda_s 1->0. Accepted in any state, including a repeated START mid-transfer. Goes to ID, clears the bit counter, busy=1.
- STOP: scl_s high on both samples and sda_s 0->1. Accepted in any state. Goes to IDLE, releases sda, busy=0. A partial byte is discarded with no write.
- Receive: bits are sampled on the scl_s rising edge, MSB first, into a shift register. Bit counter runs 7 down to 0.
- ACK slot:
  - On the scl_s falling edge after the 8th bit, drive sda low if an ACK is due.
  - Release sda on the next scl_s falling edge.
- States: IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ID byte:
  - If [7:1] == DEVICE_ID[7:1]: ACK. R/W=0 goes to SUB; R/W=1 goes to RDATA.
  - On mismatch: no ACK, go to IGNORE, nack_count+1. IGNORE waits for START or STOP.
- SUB: byte is loaded into the sub_addr pointer, then ACK, then WDATA.
- WDATA:
  - On the 8th rising edge, the next clk writes regfile[sub_addr]=byte.
  - reg_wr_en=1 for exactly one clk, with reg_wr_addr/reg_wr_data valid that cycle.
  - sub_addr+1, wrapping 8'hFF->8'h00. Then ACK and further bytes (burst).
- RDATA:
  - Load regfile[sub_addr] at entry.
  - Drive each bit on the scl_s falling edge: bit 7 on the falling edge ending the ID ACK. sda low for a 0, released for a 1.
  - After 8 bits, release sda on the falling edge; sub_addr+1 (wrap).
  - RDATA_ACK samples the initiator's bit on the rising edge. 0 continues RDATA with the next byte. 1 (NACK) goes to IGNORE, with sda released.
- Simultaneous events: a STOP/START detect has priority over bit sampling in the same clk.
- sda is never driven while scl_s is high, except when holding a bit/ACK already set up during low.
- Reset (any time, including mid-byte):
  - Next clk: state IDLE, sda released, busy=0, reg_wr_en=0, reg_wr_addr=0, reg_wr_data=0, sub_addr=0, nack_count=0, synchronizers at 1.
  - Register file cleared to 8'h00.
- dbg_data reflects writes from the clk after the reg_wr_en pulse.

Test Plan:
- Write: START, 0x42, 0x12, 0x80, STOP -> three ACKs (sda=0 in each 9th SCL-high); one reg_wr_en pulse with addr 0x12 / data 0x80; dbg_data@0x12=0x80; busy low after STOP.
- Wrong ID: START, 0x60, 0x12, 0x55, STOP -> sda never driven; no reg_wr_en; regfile[0x12] unchanged; nack_count=1.
- Burst wrap: START, 0x42, 0xFE, 0x11, 0x22, 0x33, STOP -> writes at 0xFE=0x11, 0xFF=0x22, 0x00=0x33; three pulses in order.
- Read: preload 0x0A=0xA5. START, 0x42, 0x0A, STOP, START, 0x43, then 8 clocks -> sda bits 1,0,1,0,0,1,0,1; initiator NACK; STOP -> state IDLE, sub_addr=0x0B.
- Abort: STOP after 4 data bits, then reset asserted mid ID byte -> no write; sda released; all outputs at reset values next clk.
- Repeated START mid-WDATA: START, 0x42, 0x20, 3 bits, START, 0x42, 0x21, 0x77, STOP -> only 0x21=0x77 written.
